// File: rtl/mixer_pkg.sv
// Shared types and helpers for the voice mixer.
//   mix_state_t  - mixer FSM state encoding (IDLE, ACCUM, OUTPUT)
//   acc_width()  - accumulator width that cannot overflow when summing n
//                  signed samples of sw bits
//   DROP_CNT_W   - width of the saturating dropped-slot counter
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mix_state_t;

  localparam int DROP_CNT_W = 8;

  function automatic int acc_width(input int n, input int sw);
    return sw + $clog2(n);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate tick generator.
// Counts 0..SAMPLE_PERIOD-1 and wraps; tick_out is high for the single
// cycle in which the counter holds SAMPLE_PERIOD-1.
// Ports:
//   clk_in   - system clock
//   rst_in   - synchronous reset, active-low (counter returns to 0)
//   tick_out - one-cycle tick once per SAMPLE_PERIOD cycles
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick_out = (r_count == LAST);

endmodule

// File: rtl/voice_mixer.sv
// Mono voice mixer. Once per sample period it snapshots all oscillator
// samples and the note-on mask, sums the active voices one per cycle and
// presents the mixed sample to the output stage.
//
// Handshake: mix_out/mix_valid_out are held stable while mix_valid_out is
// high; a transfer happens on any clock edge where mix_valid_out and
// mix_ready_in are both high. mix_ready_in may depend combinationally on
// mix_valid_out. A sample tick arriving while a sample is still being
// built or waiting for the consumer is dropped and counted.
//
// Build option MIXER_SATURATE_EN: when defined the sum is not scaled but
// clamped to the OUT_WIDTH signed range, and overflow_out is a sticky clip
// flag. When undefined the sum is divided by NUM_OSCILLATORS with an
// arithmetic shift (rounds toward -inf) and overflow_out is tied to 0.
//
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous reset, active-low
//   osc_samples_in  - per-voice signed samples
//   is_on_in        - per-voice note-on gate
//   mix_out         - signed mixed sample
//   mix_valid_out   - mix_out holds a valid sample
//   mix_ready_in    - consumer accepts the sample
//   drop_count_out  - saturating count of dropped sample slots
//   overflow_out    - sticky clip flag (saturating build only)
//   state_dbg_out   - current FSM state
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int OUT_WIDTH       = 16,
  parameter int SAMPLE_PERIOD   = 2268
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_samples_in,
  input  logic [NUM_OSCILLATORS-1:0]                   is_on_in,
  output logic [OUT_WIDTH-1:0]                         mix_out,
  output logic                                         mix_valid_out,
  input  logic                                         mix_ready_in,
  output logic [DROP_CNT_W-1:0]                        drop_count_out,
  output logic                                         overflow_out,
  output mix_state_t                                   state_dbg_out
);

  localparam int ACC_W    = acc_width(NUM_OSCILLATORS, SAMPLE_WIDTH);
  localparam int SHIFT    = $clog2(NUM_OSCILLATORS);
  localparam int IDX_W    = SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OSCILLATORS - 1);

  mix_state_t                                   r_state;
  mix_state_t                                   w_state_next;
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] r_snap;
  logic [NUM_OSCILLATORS-1:0]                   r_mask;
  logic signed [ACC_W-1:0]                      r_acc;
  logic [IDX_W-1:0]                             r_idx;
  logic [OUT_WIDTH-1:0]                         r_mix;
  logic                                         r_valid;
  logic [DROP_CNT_W-1:0]                        r_drop;

  logic                                         w_tick;
  logic                                         w_drop;
  logic signed [SAMPLE_WIDTH-1:0]               w_sel;
  logic signed [ACC_W-1:0]                      w_term;
  logic signed [ACC_W-1:0]                      w_acc_sum;
  logic [OUT_WIDTH-1:0]                         w_mix;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(w_tick)
  );

  // Current voice term; the size cast of a signed value sign-extends.
  always_comb begin
    w_sel     = r_snap[r_idx];
    w_term    = r_mask[r_idx] ? ACC_W'(w_sel) : '0;
    w_acc_sum = r_acc + w_term;
  end

`ifdef MIXER_SATURATE_EN
  // Compare in a width that holds both the accumulator and the output
  // range limits, so the clamp bounds are representable.
  localparam int CMP_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
  localparam logic signed [CMP_W-1:0] MAX_V =
    {{(CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] MIN_V = ~MAX_V;

  logic signed [CMP_W-1:0] w_wide;
  logic                    w_clip;
  logic                    r_overflow;

  always_comb begin
    w_wide = CMP_W'(w_acc_sum);
    w_clip = 1'b0;
    w_mix  = OUT_WIDTH'(w_wide);
    if (w_wide > MAX_V) begin
      w_mix  = OUT_WIDTH'(MAX_V);
      w_clip = 1'b1;
    end else if (w_wide < MIN_V) begin
      w_mix  = OUT_WIDTH'(MIN_V);
      w_clip = 1'b1;
    end
  end

  assign overflow_out = r_overflow;
`else
  // Divide by the voice count; the shifted value has SAMPLE_WIDTH
  // significant bits and OUT_WIDTH >= SAMPLE_WIDTH, so it always fits.
  logic signed [ACC_W-1:0] w_shifted;

  always_comb begin
    w_shifted = w_acc_sum >>> SHIFT;
    w_mix     = OUT_WIDTH'(w_shifted);
  end

  assign overflow_out = 1'b0;
`endif

  // A tick can only be taken in IDLE; anywhere else the slot is lost,
  // including the cycle in which OUTPUT completes its handshake.
  assign w_drop = w_tick && (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_next = ACCUM;
      ACCUM:   if (r_idx == LAST_IDX) w_state_next = OUTPUT;
      OUTPUT:  if (r_valid && mix_ready_in) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_mask  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_mix   <= '0;
      r_valid <= 1'b0;
      r_drop  <= '0;
`ifdef MIXER_SATURATE_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_snap <= osc_samples_in;
            r_mask <= is_on_in;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        ACCUM: begin
          r_acc <= w_acc_sum;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_mix   <= w_mix;
            r_valid <= 1'b1;
`ifdef MIXER_SATURATE_EN
            if (w_clip) r_overflow <= 1'b1;
`endif
          end
        end
        OUTPUT: begin
          if (r_valid && mix_ready_in) r_valid <= 1'b0;
        end
        default: ;
      endcase
      if (w_drop && (r_drop != {DROP_CNT_W{1'b1}})) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign mix_out        = r_mix;
  assign mix_valid_out  = r_valid;
  assign drop_count_out = r_drop;
  assign state_dbg_out  = r_state;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed testbench for voice_mixer (4 voices, 16-bit, period 16).
// Inputs are driven just after the falling edge; outputs are sampled on
// the falling edge, away from the active rising edge.
module tb_voice_mixer;
  import mixer_pkg::*;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int OW = 16;
  localparam int SP = 16;

`ifdef MIXER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][SW-1:0] samples;
  logic [N-1:0]         is_on;
  logic [OW-1:0]        mix_out;
  logic                 mix_valid;
  logic                 mix_ready;
  logic [7:0]           drop_count;
  logic                 overflow;
  mix_state_t           dbg_state;

  int checks = 0;
  int errors = 0;

  voice_mixer #(
    .NUM_OSCILLATORS(N),
    .SAMPLE_WIDTH   (SW),
    .OUT_WIDTH      (OW),
    .SAMPLE_PERIOD  (SP)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .osc_samples_in(samples),
    .is_on_in      (is_on),
    .mix_out       (mix_out),
    .mix_valid_out (mix_valid),
    .mix_ready_in  (mix_ready),
    .drop_count_out(drop_count),
    .overflow_out  (overflow),
    .state_dbg_out (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic wait_state(input mix_state_t s, input int budget, output bit ok);
    int n;
    n = 0;
    while (dbg_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (dbg_state == s);
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n = 0;
    while (mix_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (mix_valid === 1'b1);
  endtask

  // Drive a vector, wait for the snapshot (first ACCUM cycle = tick+1) and
  // then for valid; lat counts cycles from tick+1 to valid.
  task automatic drive_and_capture(input logic [N-1:0][SW-1:0] s, input logic [N-1:0] m,
                                   output logic [OW-1:0] got, output int lat, output bit ok);
    bit ok1, ok2;
    samples = s;
    is_on   = m;
    wait_state(ACCUM, 3 * SP, ok1);
    wait_valid(4 * N, lat, ok2);
    got = mix_out;
    ok  = ok1 && ok2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n     = 1'b0;
    mix_ready = 1'b0;
    samples   = '0;
    is_on     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mix_valid !== 1'b0 || mix_out !== '0 || drop_count !== 8'd0 ||
        overflow !== 1'b0 || dbg_state != IDLE) begin
      errors++;
      $display("FAIL reset_state: got valid=%b mix=%0d drop=%0d ovf=%b st=%0d, expected all 0 / IDLE",
               mix_valid, $signed(mix_out), drop_count, overflow, dbg_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mix;
    logic [N-1:0][SW-1:0] s;
    logic [OW-1:0] got;
    logic signed [OW-1:0] exp_v;
    int lat;
    bit ok;
    s[0] = 16'd1000; s[1] = 16'd2000; s[2] = 16'd3000; s[3] = 16'd4000;
    exp_v = SAT ? 16'sd10000 : 16'sd2500;
    mix_ready = 1'b1;
    drive_and_capture(s, 4'b1111, got, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mix_timeout: got no valid, expected valid within budget");
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL mix_latency: got tick+%0d, expected tick+5", lat + 1);
    end
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL mix_value: got %0d, expected %0d", $signed(got), exp_v);
    end
    @(negedge clk);
    checks++;
    if (mix_valid !== 1'b0) begin
      errors++;
      $display("FAIL mix_one_cycle: got valid=%b, expected 0", mix_valid);
    end
  endtask

  task automatic test_mask;
    logic [N-1:0][SW-1:0] s;
    logic [OW-1:0] got;
    logic signed [OW-1:0] exp_v;
    int lat;
    bit ok;
    // single voice, negative
    s[0] = -16'sd4000; s[1] = 16'd7; s[2] = 16'd7; s[3] = 16'd7;
    exp_v = SAT ? -16'sd4000 : -16'sd1000;
    drive_and_capture(s, 4'b0001, got, lat, ok);
    checks++;
    if (!ok || got !== exp_v) begin
      errors++;
      $display("FAIL mask_one: got ok=%b %0d, expected %0d", ok, $signed(got), exp_v);
    end
    @(negedge clk);
    // -1 / 4 rounds toward -inf
    s[0] = 16'hFFFF; s[1] = 16'd0; s[2] = 16'd0; s[3] = 16'd0;
    exp_v = -16'sd1;
    drive_and_capture(s, 4'b0001, got, lat, ok);
    checks++;
    if (!ok || got !== exp_v) begin
      errors++;
      $display("FAIL mask_floor: got ok=%b %0d, expected %0d", ok, $signed(got), exp_v);
    end
    @(negedge clk);
    // masked voices at 2 and 3 only: (-100 + 300)
    s[0] = 16'd5000; s[1] = 16'd5000; s[2] = -16'sd100; s[3] = 16'd300;
    exp_v = SAT ? 16'sd200 : 16'sd50;
    drive_and_capture(s, 4'b1100, got, lat, ok);
    checks++;
    if (!ok || got !== exp_v) begin
      errors++;
      $display("FAIL mask_upper: got ok=%b %0d, expected %0d", ok, $signed(got), exp_v);
    end
    @(negedge clk);
    // empty mask still produces a valid zero
    s[0] = 16'd1234; s[1] = 16'd1234; s[2] = 16'd1234; s[3] = 16'd1234;
    drive_and_capture(s, 4'b0000, got, lat, ok);
    checks++;
    if (!ok || got !== 16'd0) begin
      errors++;
      $display("FAIL mask_empty: got valid_seen=%b %0d, expected valid and 0", ok, $signed(got));
    end
    @(negedge clk);
  endtask

  task automatic test_snapshot;
    logic signed [OW-1:0] exp_v;
    logic [OW-1:0] got;
    int lat;
    bit ok1, ok2;
    samples[0] = 16'd100; samples[1] = 16'd200; samples[2] = 16'd300; samples[3] = 16'd400;
    is_on = 4'b1111;
    exp_v = SAT ? 16'sd1000 : 16'sd250;
    wait_state(ACCUM, 3 * SP, ok1);
    // one cycle after the tick: disturb every input
    samples = '0;
    is_on   = 4'b0000;
    wait_valid(4 * N, lat, ok2);
    got = mix_out;
    checks++;
    if (!ok1 || !ok2 || got !== exp_v) begin
      errors++;
      $display("FAIL snapshot: got ok=%b%b %0d, expected %0d", ok1, ok2, $signed(got), exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic [N-1:0][SW-1:0] s;
    logic [OW-1:0] got;
    logic signed [OW-1:0] exp_a, exp_b;
    int lat;
    bit ok;
    exp_a = SAT ? 16'sd1600 : 16'sd400;
    exp_b = SAT ? 16'sd3200 : 16'sd800;
    mix_ready = 1'b0;
    s[0] = 16'd400; s[1] = 16'd400; s[2] = 16'd400; s[3] = 16'd400;
    drive_and_capture(s, 4'b1111, got, lat, ok);
    checks++;
    if (!ok || got !== exp_a) begin
      errors++;
      $display("FAIL stall_first: got ok=%b %0d, expected %0d", ok, $signed(got), exp_a);
    end
    samples[0] = 16'd800; samples[1] = 16'd800; samples[2] = 16'd800; samples[3] = 16'd800;
    repeat (20) @(negedge clk);  // one more tick passes while stalled
    checks++;
    if (mix_valid !== 1'b1 || mix_out !== exp_a) begin
      errors++;
      $display("FAIL stall_hold: got valid=%b %0d, expected 1 %0d", mix_valid, $signed(mix_out), exp_a);
    end
    checks++;
    if (drop_count !== 8'd1) begin
      errors++;
      $display("FAIL stall_drop: got %0d, expected 1", drop_count);
    end
    mix_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mix_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got valid=%b, expected 0", mix_valid);
    end
    drive_and_capture(samples, 4'b1111, got, lat, ok);
    checks++;
    if (!ok || got !== exp_b) begin
      errors++;
      $display("FAIL stall_fresh: got ok=%b %0d, expected %0d", ok, $signed(got), exp_b);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate;
    logic [N-1:0][SW-1:0] s;
    logic [OW-1:0] got;
    logic signed [OW-1:0] exp_v;
    logic exp_ovf;
    int lat;
    bit ok;
    s[0] = 16'd30000; s[1] = 16'd30000; s[2] = 16'd30000; s[3] = 16'd30000;
    exp_v   = SAT ? 16'sd32767 : 16'sd30000;
    exp_ovf = SAT;
    drive_and_capture(s, 4'b1111, got, lat, ok);
    checks++;
    if (!ok || got !== exp_v) begin
      errors++;
      $display("FAIL sat_value: got ok=%b %0d, expected %0d", ok, $signed(got), exp_v);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL sat_flag: got %b, expected %b", overflow, exp_ovf);
    end
    @(negedge clk);
    s[0] = 16'd1; s[1] = 16'd1; s[2] = 16'd1; s[3] = 16'd1;
    exp_v = SAT ? 16'sd4 : 16'sd1;
    drive_and_capture(s, 4'b1111, got, lat, ok);
    checks++;
    if (!ok || got !== exp_v || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL sat_sticky: got ok=%b %0d ovf=%b, expected %0d ovf=%b",
               ok, $signed(got), overflow, exp_v, exp_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_saturate;
    mix_ready = 1'b0;
    repeat (SP * 260) @(negedge clk);
    checks++;
    if (drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d, expected 255", drop_count);
    end
    mix_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    mix_ready = 1'b1;
    samples[0] = 16'd40; samples[1] = 16'd40; samples[2] = 16'd40; samples[3] = 16'd40;
    is_on = 4'b1111;
    wait_state(ACCUM, 3 * SP, ok);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || mix_valid !== 1'b0 || mix_out !== '0 || drop_count !== 8'd0 ||
        overflow !== 1'b0 || dbg_state != IDLE) begin
      errors++;
      $display("FAIL reset_mid: got accum_seen=%b valid=%b mix=%0d drop=%0d ovf=%b st=%0d, expected 1/0/0/0/0/IDLE",
               ok, mix_valid, $signed(mix_out), drop_count, overflow, dbg_state);
    end
    // This cycle (first after the reset edge) is cycle 1; valid due in cycle 21.
    rst_n = 1'b1;
    wait_valid(40, n, ok);
    checks++;
    if (!ok || n !== 20) begin
      errors++;
      $display("FAIL reset_restart: got valid_seen=%b at cycle %0d, expected cycle 21", ok, n + 1);
    end
    checks++;
    if (mix_out !== (SAT ? 16'd160 : 16'd40)) begin
      errors++;
      $display("FAIL reset_restart_value: got %0d, expected %0d", $signed(mix_out), SAT ? 160 : 40);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mix();
    test_mask();
    test_snapshot();
    test_stall();
    test_saturate();
    test_drop_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
